// File: rtl/shift_reg_seq_arb.sv
// Purpose: round-robin arbiter for two clients that streams a word into an external serial shift register and returns its read-back.
// Latency: response valid k + N + (N-1)*GAP + 2 edges after the request handshake at edge k.
// Backpressure: the response is held until rsp_ready; no new request is granted until the response handshake completes.
module shift_reg_seq_arb #(
  parameter int N   = 4,
  parameter int GAP = 0   // idle cycles between shift pulses, 0..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_data,
  input  logic         req0_dir,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_data,
  input  logic         req1_dir,
  output logic         sr_d,
  output logic         sr_en,
  output logic         sr_dir,
  input  logic [N-1:0] sr_q,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_q,
  output logic         rsp_match
);

  localparam int            CW       = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAPW,
    CHECK,
    RESP
  } state_t;

  state_t        state, state_nxt;
  logic          ptr, ptr_nxt;              // round-robin: side that wins a tie
  logic [CW-1:0] cnt, cnt_nxt;              // shift pulses issued so far
  logic [3:0]    gcnt, gcnt_nxt;            // idle cycles spent in the current gap
  logic          settled, settled_nxt;      // final shift has landed in sr_q
  logic [N-1:0]  feed, feed_nxt;            // bits still to send, next one at [0]
  logic [N-1:0]  word, word_nxt;            // latched request word for the compare
  logic          dir_r, dir_nxt;
  logic          id_r, id_nxt;
  logic          sr_d_nxt, sr_en_nxt, sr_dir_nxt;
  logic          rsp_valid_nxt, rsp_id_nxt, rsp_match_nxt;
  logic [N-1:0]  rsp_q_nxt;
  logic          grant0, grant1;

  // Left shifts must see the MSB first, so the word is reversed once at
  // latch time; the shifter then always sends feed[0] and shifts right.
  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i] = v[N-1-i];
    end
    return r;
  endfunction

  // Next-state, registered-output next values and the combinational readys.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    gcnt_nxt      = gcnt;
    settled_nxt   = settled;
    feed_nxt      = feed;
    word_nxt      = word;
    dir_nxt       = dir_r;
    id_nxt        = id_r;
    sr_d_nxt      = sr_d;
    sr_en_nxt     = 1'b0;
    sr_dir_nxt    = sr_dir;
    rsp_valid_nxt = rsp_valid;
    rsp_id_nxt    = rsp_id;
    rsp_q_nxt     = rsp_q;
    rsp_match_nxt = rsp_match;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;

    // A lone requester always wins; on a tie the pointer side wins.
    grant0 = req0_valid & (~req1_valid | ~ptr);
    grant1 = req1_valid & (~req0_valid | ptr);

    case (state)
      IDLE: begin
        // Readys are gated by reset so no handshake can slip through it.
        req0_ready = rst & grant0;
        req1_ready = rst & grant1;
        if (req0_ready) begin
          word_nxt  = req0_data;
          dir_nxt   = req0_dir;
          id_nxt    = 1'b0;
          feed_nxt  = req0_dir ? bit_rev(req0_data) : req0_data;
          cnt_nxt   = '0;
          ptr_nxt   = 1'b1;
          state_nxt = SHIFT;
        end else if (req1_ready) begin
          word_nxt  = req1_data;
          dir_nxt   = req1_dir;
          id_nxt    = 1'b1;
          feed_nxt  = req1_dir ? bit_rev(req1_data) : req1_data;
          cnt_nxt   = '0;
          ptr_nxt   = 1'b0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        sr_en_nxt  = 1'b1;
        sr_d_nxt   = feed[0];
        sr_dir_nxt = dir_r;
        feed_nxt   = feed >> 1;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          settled_nxt = 1'b0;
          state_nxt   = CHECK;
        end else if (GAP > 0) begin
          gcnt_nxt  = '0;
          state_nxt = GAPW;
        end
      end

      GAPW: begin
        gcnt_nxt = gcnt + 4'd1;
        if (gcnt == GAP_LAST) begin
          state_nxt = SHIFT;
        end
      end

      CHECK: begin
        // The last pulse is still on sr_en during the first CHECK cycle, so
        // the register only holds the full word one cycle later.
        if (!settled) begin
          settled_nxt = 1'b1;
        end else begin
          rsp_q_nxt     = sr_q;
          rsp_match_nxt = (sr_q == word);
          rsp_id_nxt    = id_r;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      gcnt      <= '0;
      settled   <= 1'b0;
      feed      <= '0;
      word      <= '0;
      dir_r     <= 1'b0;
      id_r      <= 1'b0;
      sr_d      <= 1'b0;
      sr_en     <= 1'b0;
      sr_dir    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      rsp_match <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gcnt      <= gcnt_nxt;
      settled   <= settled_nxt;
      feed      <= feed_nxt;
      word      <= word_nxt;
      dir_r     <= dir_nxt;
      id_r      <= id_nxt;
      sr_d      <= sr_d_nxt;
      sr_en     <= sr_en_nxt;
      sr_dir    <= sr_dir_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_q     <= rsp_q_nxt;
      rsp_match <= rsp_match_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_seq_arb.sv
// Purpose: directed bench for shift_reg_seq_arb with behavioural shift registers and a response scoreboard.
// Latency: checks response timing for GAP=0 and GAP=1 instances.
// Backpressure: exercises a held response with both requesters valid.
module tb_shift_reg_seq_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;     // 0: drive/observe GAP=0 instance, 1: GAP=1 instance
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic       req0_dir = 1'b0, req1_dir = 1'b0;
  logic       rsp_ready = 1'b1;
  logic       stuck0 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int last_rsp = 0;
  logic both_hi = 1'b0;
  logic [5:0] exp_q[$];       // {id, q[3:0], match}

  // GAP=0 instance wiring
  logic       a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
  logic       a_sr_d, a_sr_en, a_sr_dir, a_rsp_valid, a_rsp_id, a_rsp_match;
  logic [3:0] a_sr_q, a_rsp_q;
  logic [3:0] a_m = 4'b0101;
  // GAP=1 instance wiring
  logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic       b_sr_d, b_sr_en, b_sr_dir, b_rsp_valid, b_rsp_id, b_rsp_match;
  logic [3:0] b_sr_q, b_rsp_q;
  logic [3:0] b_m = 4'b0011;
  // observed view of the selected instance
  logic       o_req0_ready, o_req1_ready, o_sr_d, o_sr_en, o_sr_dir;
  logic       o_rsp_valid, o_rsp_id, o_rsp_match;
  logic [3:0] o_rsp_q;

  assign a_req0_valid = req0_valid & ~sel;
  assign a_req1_valid = req1_valid & ~sel;
  assign b_req0_valid = req0_valid & sel;
  assign b_req1_valid = req1_valid & sel;

  assign o_req0_ready = sel ? b_req0_ready : a_req0_ready;
  assign o_req1_ready = sel ? b_req1_ready : a_req1_ready;
  assign o_sr_d       = sel ? b_sr_d       : a_sr_d;
  assign o_sr_en      = sel ? b_sr_en      : a_sr_en;
  assign o_sr_dir     = sel ? b_sr_dir     : a_sr_dir;
  assign o_rsp_valid  = sel ? b_rsp_valid  : a_rsp_valid;
  assign o_rsp_id     = sel ? b_rsp_id     : a_rsp_id;
  assign o_rsp_q      = sel ? b_rsp_q      : a_rsp_q;
  assign o_rsp_match  = sel ? b_rsp_match  : a_rsp_match;

  shift_reg_seq_arb #(.N(4), .GAP(0)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_data(req0_data), .req0_dir(req0_dir),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_data(req1_data), .req1_dir(req1_dir),
    .sr_d(a_sr_d), .sr_en(a_sr_en), .sr_dir(a_sr_dir), .sr_q(a_sr_q),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id), .rsp_q(a_rsp_q), .rsp_match(a_rsp_match)
  );

  shift_reg_seq_arb #(.N(4), .GAP(1)) u_dut_gap (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_data(req0_data), .req0_dir(req0_dir),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_data(req1_data), .req1_dir(req1_dir),
    .sr_d(b_sr_d), .sr_en(b_sr_en), .sr_dir(b_sr_dir), .sr_q(b_sr_q),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_q(b_rsp_q), .rsp_match(b_rsp_match)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bidirectional shift registers: dir=1 left (d into Q[0]), dir=0 right (d into Q[3]).
  always @(posedge clk) if (a_sr_en) a_m <= a_sr_dir ? {a_m[2:0], a_sr_d} : {a_sr_d, a_m[3:1]};
  always @(posedge clk) if (b_sr_en) b_m <= b_sr_dir ? {b_m[2:0], b_sr_d} : {b_sr_d, b_m[3:1]};
  assign a_sr_q = a_m & ~{3'b000, stuck0};
  assign b_sr_q = b_m;

  always @(negedge clk) begin
    if ((a_req0_ready && a_req1_ready) || (b_req0_ready && b_req1_ready)) both_hi = 1'b1;
  end

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a ready, check who was granted, take the handshake edge.
  task automatic grant(input string tag, input int exp_who, input int exp_gap);
    int n;
    logic who;
    n = 0;
    #1;
    while (!(o_req0_ready === 1'b1 || o_req1_ready === 1'b1) && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_gnt_timeout"}, 32'(o_req0_ready | o_req1_ready), 1);
    who = o_req1_ready;
    chk({tag, "_who"}, 32'(who), exp_who);
    tick();
    hs_cyc = cyc;
    if (exp_gap > 0) chk({tag, "_b2b"}, hs_cyc - last_rsp, exp_gap);
  endtask

  // Follow one command from handshake to response handshake.
  task automatic collect(input string tag, input int lat, input logic [31:0] en_exp,
                         input logic [3:0] d_exp, input logic dir_exp, input int hold);
    logic [31:0] en_pat;
    logic [3:0]  d_pat, q0;
    logic        dir_ok, stable, rdy_bad, id0;
    logic [5:0]  e;
    int          n;
    en_pat = '0; d_pat = '0; dir_ok = 1'b1; n = 0;
    do begin
      tick();
      n++;
      en_pat = {en_pat[30:0], o_sr_en};
      if (o_sr_en) begin
        d_pat = {d_pat[2:0], o_sr_d};
        if (o_sr_dir !== dir_exp) dir_ok = 1'b0;
      end
    end while (o_rsp_valid !== 1'b1 && n < 100);
    chk({tag, "_rsp_timeout"}, 32'(o_rsp_valid), 1);
    chk({tag, "_latency"}, cyc - hs_cyc, lat);
    chk({tag, "_en_pattern"}, en_pat, en_exp);
    chk({tag, "_d_seq"}, 32'(d_pat), 32'(d_exp));
    chk({tag, "_sr_dir"}, 32'(dir_ok), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 6'h3f;
    chk({tag, "_rsp_id"}, 32'(o_rsp_id), 32'(e[5]));
    chk({tag, "_rsp_q"}, 32'(o_rsp_q), 32'(e[4:1]));
    chk({tag, "_rsp_match"}, 32'(o_rsp_match), 32'(e[0]));
    q0 = o_rsp_q; id0 = o_rsp_id; stable = 1'b1; rdy_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (o_rsp_valid !== 1'b1 || o_rsp_q !== q0 || o_rsp_id !== id0) stable = 1'b0;
      if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) rdy_bad = 1'b1;
    end
    chk({tag, "_hold_stable"}, 32'(stable), 1);
    chk({tag, "_hold_no_ready"}, 32'(rdy_bad), 0);
    rsp_ready = 1'b1;
    tick();
    last_rsp = cyc;
    chk({tag, "_rsp_drop"}, 32'(o_rsp_valid), 0);
  endtask

  initial begin
    // Reset: outputs cleared and readys low even with a valid request.
    rst = 1'b0; req0_valid = 1'b1; req0_data = 4'b1011; req0_dir = 1'b1;
    tick(); tick(); tick();
    chk("rst_sr_en", 32'(o_sr_en), 0);
    chk("rst_sr_d", 32'(o_sr_d), 0);
    chk("rst_sr_dir", 32'(o_sr_dir), 0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rsp_id", 32'(o_rsp_id), 0);
    chk("rst_rsp_q", 32'(o_rsp_q), 0);
    chk("rst_rsp_match", 32'(o_rsp_match), 0);
    chk("rst_req0_ready", 32'(o_req0_ready), 0);
    rst = 1'b1;

    // T1: req0 1011 left; inputs scrambled while busy must not matter.
    exp_q.push_back({1'b0, 4'b1011, 1'b1});
    grant("t1", 0, 0);
    req0_valid = 1'b0; req0_data = 4'hF; req0_dir = 1'b0;
    collect("t1", 6, 32'b111100, 4'b1011, 1'b1, 0);

    // T2: req1 0110 right.
    req1_data = 4'b0110; req1_dir = 1'b0; req1_valid = 1'b1;
    exp_q.push_back({1'b1, 4'b0110, 1'b1});
    grant("t2", 1, 0);
    req1_valid = 1'b0; req1_data = 4'h9;
    collect("t2", 6, 32'b111100, rev4(4'b0110), 1'b0, 0);

    // T3: both valid continuously, expect alternating service back-to-back.
    req0_data = 4'hA; req0_dir = 1'b1; req1_data = 4'h5; req1_dir = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        exp_q.push_back({1'b0, 4'hA, 1'b1});
        grant($sformatf("t3_%0d", i), 0, (i > 0) ? 1 : 0);
        collect($sformatf("t3_%0d", i), 6, 32'b111100, 4'hA, 1'b1, 0);
      end else begin
        exp_q.push_back({1'b1, 4'h5, 1'b1});
        grant($sformatf("t3_%0d", i), 1, 1);
        collect($sformatf("t3_%0d", i), 6, 32'b111100, rev4(4'h5), 1'b0, 0);
      end
    end

    // T5: response held 5 cycles with both requesters valid, then req1 next cycle.
    req0_data = 4'b0011; req0_dir = 1'b0; req1_data = 4'b1001; req1_dir = 1'b1;
    exp_q.push_back({1'b0, 4'b0011, 1'b1});
    grant("t5", 0, 0);
    rsp_ready = 1'b0;
    collect("t5", 6, 32'b111100, rev4(4'b0011), 1'b0, 5);
    exp_q.push_back({1'b1, 4'b1001, 1'b1});
    grant("t5b", 1, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    collect("t5b", 6, 32'b111100, 4'b1001, 1'b1, 0);

    // T6: reset after the second shift pulse aborts the command.
    req0_data = 4'b1001; req0_dir = 1'b1; req0_valid = 1'b1;
    grant("t6", 0, 0);
    req0_valid = 1'b0;
    tick(); tick();
    chk("t6_pulse2_en", 32'(o_sr_en), 1);
    rst = 1'b0; req1_data = 4'b1110; req1_dir = 1'b0; req1_valid = 1'b1;
    tick();
    chk("t6_rst_sr_en", 32'(o_sr_en), 0);
    chk("t6_rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("t6_rst_req1_ready", 32'(o_req1_ready), 0);
    rst = 1'b1;
    #1;
    chk("t6_rel_req1_ready", 32'(o_req1_ready), 1);
    chk("t6_rel_req0_ready", 32'(o_req0_ready), 0);
    exp_q.push_back({1'b1, 4'b1110, 1'b1});
    grant("t6b", 1, 0);
    req1_valid = 1'b0;
    collect("t6b", 6, 32'b111100, rev4(4'b1110), 1'b0, 0);

    // T7: Q[0] stuck at 0 must produce a mismatch.
    stuck0 = 1'b1;
    req0_data = 4'b0001; req0_dir = 1'b1; req0_valid = 1'b1;
    exp_q.push_back({1'b0, 4'b0000, 1'b0});
    grant("t7", 0, 0);
    req0_valid = 1'b0;
    collect("t7", 6, 32'b111100, 4'b0001, 1'b1, 0);
    stuck0 = 1'b0;

    // T8: GAP=1 instance, one idle cycle between pulses.
    sel = 1'b1;
    req0_data = 4'b1100; req0_dir = 1'b1; req0_valid = 1'b1;
    exp_q.push_back({1'b0, 4'b1100, 1'b1});
    grant("t8", 0, 0);
    req0_valid = 1'b0;
    collect("t8", 9, 32'b101010100, 4'b1100, 1'b1, 0);

    chk("never_both_ready", 32'(both_hi), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq_arb.md
Name: shift_reg_seq_arb

Overview:
- Controller for the team's N-bit bidirectional serial shift register (serial input d, shift enable, direction select, parallel output Q).
- Arbitrates round-robin between two requesters. Each requester submits a parallel word and a direction.
- Streams the word serially into the register with the correct bit order. Reads back Q and returns a response with a match flag.
- Sits between the register and its two client blocks; it is the only driver of the register's d/en/dir.

Parameters:
N, 4, width of the shift register and of request/response words
GAP, 0, idle cycles (sr_en=0) inserted between consecutive shift pulses; 0..15

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
req0_valid  input  1  requester 0 has a command
req0_ready  output  1  requester 0 command accepted this cycle
req0_data  input  N  word to load, requester 0
req0_dir  input  1  direction, requester 0 (1=left, 0=right)
req1_valid  input  1  requester 1 has a command
req1_ready  output  1  requester 1 command accepted this cycle
req1_data  input  N  word to load, requester 1
req1_dir  input  1  direction, requester 1
sr_d  output  1  serial bit to shift register
sr_en  output  1  shift enable to shift register
sr_dir  output  1  direction to shift register
sr_q  input  N  shift register parallel output Q
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester index of the response
rsp_q  output  N  sr_q captured after final shift
rsp_match  output  1  rsp_q == requested word

Behaviour:
- Shift convention: dir=1 means left shift, d enters Q[0]; dir=0 means right shift, d enters Q[N-1].
- Feed order: dir=1 feeds data[N-1] first and data[0] last. dir=0 feeds data[0] first and data[N-1] last. After N enabled shifts, Q equals the word.
- FSM states: IDLE, SHIFT, GAPW, CHECK, RESP.
- IDLE:
  - reqX_ready = 1 combinationally for the granted requester only when it is valid; the other ready is 0.
  - Handshake = valid & ready at a clock edge. On handshake: latch data, dir and id; clear the bit counter; go to SHIFT.
- Arbitration: round-robin pointer, reset value 0. If only one requester is valid, it wins. If both are valid, the pointer side wins. After each grant, the pointer moves to the other requester.
- SHIFT:
  - Registered outputs are sr_en=1, sr_dir=latched dir, sr_d=current bit; each lasts exactly one cycle.
  - Counter increments each SHIFT cycle.
  - After the Nth pulse, go to CHECK.
  - Otherwise go to GAPW if GAP>0, else stay in SHIFT.
- GAPW: sr_en=0 for exactly GAP cycles. sr_d and sr_dir hold their last values. Then return to SHIFT.
- CHECK: sr_en=0. Capture sr_q into rsp_q and compute rsp_match. Go to RESP.
- RESP: rsp_valid=1 with rsp_id/rsp_q/rsp_match stable. Hold until rsp_valid & rsp_ready, then return to IDLE.
  - No new grant while in SHIFT/GAPW/CHECK/RESP; both readys are 0.
- Latency: handshake at edge k.
  - sr_en is high in the cycles after edges k+1 .. k+N (GAP=0).
  - rsp_valid rises after edge k+N+2.
  - General case: first rsp_valid at edge k + N + (N-1)*GAP + 2.
- Back-to-back operation: the earliest next handshake is the cycle after the response handshake (one IDLE cycle minimum).
- rsp_ready high while not in RESP has no effect.
- Request inputs change while busy: ignored; the latched copy is used.
- Reset (rst=0 at an edge):
  - state=IDLE, pointer=0.
  - sr_d=sr_en=sr_dir=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_match=0, req readys=0 during reset.
  - Reset mid-operation aborts the command: sr_en is 0 from the next edge, no response is produced, and the aborted command is not retried.
- The controller never resets the shift register. Bits already shifted remain in Q; the final Q depends only on the last N shifts.

Test Plan:
- Single req0, data=4'b1011, dir=1, GAP=0 -> sr_en high 4 consecutive cycles; sr_d sequence 1,0,1,1; sr_dir=1; rsp_valid at handshake+6 edges; rsp_id=0, rsp_q=4'b1011, rsp_match=1.
- Single req1, data=4'b0110, dir=0, GAP=0 -> sr_d sequence 0,1,1,0; sr_dir=0; rsp_id=1, rsp_q=4'b0110, rsp_match=1.
- Both valid from reset (req0=4'hA/dir1, req1=4'h5/dir0), rsp_ready=1 -> req0 served first, then req1. Repeat both -> order 0,1,0,1; readys never both high.
- GAP=1 build, data=4'b1100, dir=1 -> sr_en pattern 1,0,1,0,1,0,1; rsp_valid at handshake+9 edges; rsp_match=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_q/rsp_id stable; req0_ready=req1_ready=0 despite valid; release -> IDLE, next grant the following cycle.
- rst=0 after the 2nd shift pulse -> next edge: sr_en=0, state IDLE, no rsp_valid. Release reset with req1 valid -> req1 granted (pointer 0, req0 idle). Separately, force sr_q bit0 stuck-at-0 with data=4'b0001 -> rsp_match=0.
